// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC update path: FSM states, branch kinds,
// PC-source mux selects and exception causes.
package pc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE_EPC,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_LOAD_PC
    } state_t;

    typedef enum logic [1:0] {
        BR_BEQ = 2'b00,
        BR_BNE = 2'b01,
        BR_BLE = 2'b10,
        BR_BGT = 2'b11
    } branch_t;

    // PC-source mux inputs; only the ends and MemDataReg matter here
    localparam logic [2:0] PCSRC_PC   = 3'b000;
    localparam logic [2:0] PCSRC_MDR  = 3'b011;
    localparam logic [2:0] PCSRC_REGA = 3'b111;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_OPCODE   = 2'b01,
        CAUSE_OVERFLOW = 2'b10,
        CAUSE_DIVZERO  = 2'b11
    } cause_t;

endpackage

// File: rtl/pc_update_unit_branch_eval.sv
// Branch outcome from the comparison kind and the ALU flags.
module branch_eval
    import pc_ctrl_pkg::*;
(
    input  logic [1:0] branch_type,
    input  logic       alu_zero,
    input  logic       alu_gt,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (branch_type)
            BR_BEQ:  taken = alu_zero;
            BR_BNE:  taken = !alu_zero;
            BR_BLE:  taken = !alu_gt;
            BR_BGT:  taken = alu_gt;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_update_unit.sv
// Program counter / EPC owner with a small exception sequencer that saves EPC,
// fetches the handler byte from the vector table and reloads PC via MemDataReg.
module pc_update_unit
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC_OPCODE   = 32'd253,
    parameter logic [31:0] VEC_OVERFLOW = 32'd254,
    parameter logic [31:0] VEC_DIVZERO  = 32'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic [2:0]  ctrl_pc_source,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_type,
    input  logic        alu_zero,
    input  logic        alu_gt,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_divzero,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic [2:0]  pc_source,
    output logic [31:0] exc_mem_addr,
    output logic        exc_mem_read,
    output logic        mdr_write,
    output logic        exc_busy,
    output logic [1:0]  exc_cause
);

    state_t      state;
    logic        taken;
    logic        exc_any;
    cause_t      cause_new;
    logic [31:0] vec_addr;

    branch_eval u_branch_eval (
        .branch_type (branch_type),
        .alu_zero    (alu_zero),
        .alu_gt      (alu_gt),
        .taken       (taken)
    );

    assign exc_any = exc_opcode | exc_overflow | exc_divzero;

    always_comb begin
        cause_new = CAUSE_DIVZERO;
        if (exc_opcode)
            cause_new = CAUSE_OPCODE;
        else if (exc_overflow)
            cause_new = CAUSE_OVERFLOW;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= '0;
            epc       <= '0;
            exc_cause <= CAUSE_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    // An exception wins over any PC write requested in the same cycle
                    if (exc_any) begin
                        exc_cause <= cause_new;
                        state     <= ST_SAVE_EPC;
                    end else if (pc_write || (pc_write_cond && taken)) begin
                        pc <= pc_next;
                    end
                end
                ST_SAVE_EPC: begin
                    // PC already points past the faulting instruction
                    epc   <= pc - 32'd4;
                    state <= ST_MEM_REQ;
                end
                ST_MEM_REQ:  state <= ST_MEM_WAIT;
                ST_MEM_WAIT: state <= ST_LOAD_PC;
                ST_LOAD_PC: begin
                    pc    <= pc_next;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (exc_cause)
            CAUSE_OPCODE:   vec_addr = VEC_OPCODE;
            CAUSE_OVERFLOW: vec_addr = VEC_OVERFLOW;
            CAUSE_DIVZERO:  vec_addr = VEC_DIVZERO;
            default:        vec_addr = '0;
        endcase
    end

    // Decoded straight from the state, but forced quiet while reset is held
    assign exc_busy     = !reset && (state != ST_IDLE);
    assign exc_mem_read = !reset && (state == ST_MEM_REQ);
    assign mdr_write    = !reset && (state == ST_MEM_WAIT);
    assign exc_mem_addr = (exc_mem_read || mdr_write) ? vec_addr : '0;
    assign pc_source    = (state == ST_LOAD_PC) ? PCSRC_MDR : ctrl_pc_source;

endmodule
